ita_activation_out_buffer: RTL and testbench
============================================

// Module: ita_activation_out_buffer
// PURPOSE
//  Downstream neighbour of the activation unit: absorbs its fixed-latency, non-stallable N_PE-lane int8 output
//  into a credit-protected FIFO and presents it to the output streamer with valid/ready backpressure.
//  Tracks in-flight rows in the activation pipeline so upstream issue stops before the FIFO can overflow.
//  Tags the final row of each output tile with last_o.
// PARAMETERS
//  N_PE         16  lanes per row (matches activation data_o)
//  WO           8   bits per lane (signed, requant output width)
//  DEPTH        4   FIFO entries; must be >= ACT_LATENCY+2 for full throughput (elaboration-time $fatal if < 1)
//  ACT_LATENCY  2   cycles from activation data_i/calc_en to data_o; must be >= 1
//  CNT_W        16  width of tile row counter
// PORTS
//  clk_i        in   1         clock, rising edge
//  rst_i        in   1         asynchronous reset, active-high
//  clear_i      in   1         synchronous flush (FIFO, valid pipe, row counter, overflow flag)
//  valid_i      in   1         a row enters activation this cycle (same cycle as activation calc_en_i/data_i)
//  issue_ready_o out 1         upstream may assert valid_i next cycle's issue; credit available
//  act_data_i   in   N_PE*WO   activation data_o; sampled when delayed valid pops out of valid pipe
//  tile_len_i   in   CNT_W     rows per output tile; quasi-static, changed only while buffer empty and idle
//  data_o       out  N_PE*WO   head-of-FIFO row
//  valid_o      out  1         head row valid
//  ready_i      in   1         downstream accepts
//  last_o       out  1         head row is last row of tile (qualified by valid_o)
//  count_o      out  $clog2(DEPTH+1)  FIFO occupancy
//  overflow_o   out  1         sticky: push attempted into full FIFO without simultaneous pop
// BEHAVIOUR
//  Reset (rst_i=1, async): valid pipe, FIFO pointers, count, row counter, overflow cleared; valid_o=0,
//   last_o=0, count_o=0, data_o=0; issue_ready_o=0 while rst_i high, DEPTH>0 -> 1 from first cycle after release.
//  Valid pipe: ACT_LATENCY-deep shift register of valid_i; push_w = pipe[ACT_LATENCY-1]; act_data_i written
//   into FIFO in that cycle (row issued at cycle t written at end of cycle t+ACT_LATENCY, visible at t+ACT_LATENCY+1).
//  Credits: inflight = popcount(pipe); issue_ready_o = (count + inflight + valid_i_reg_none) < DEPTH, i.e.
//   (count + inflight) < DEPTH; pop in same cycle NOT credited (registered-path friendly, conservative).
//  valid_i while issue_ready_o=0: protocol violation; still enters pipe; overflow handled as below.
//  FIFO: show-ahead; valid_o = (count != 0); pop = valid_o & ready_i; data_o stable while valid_o & !ready_i.
//  Simultaneous push+pop: count unchanged, allowed also when full (no overflow).
//  Push when full without pop: row dropped, overflow_o set, sticky until clear_i or rst_i.
//  Pop when empty: impossible (valid_o=0); ready_i ignored.
//  Row counter: increments on pop; last_o = valid_o & (row_cnt == tile_len_i-1); on pop of last row row_cnt
//   wraps to 0. tile_len_i==0 treated as 1 (every row last). Counter saturates never; width CNT_W.
//  clear_i: same-cycle effect at next edge: pipe, FIFO, row_cnt, overflow zeroed; push_w and pop in that
//   cycle discarded; clear_i has priority over all events. rst_i mid-operation: all in-flight rows lost.
//  Throughput: with ready_i=1 continuous and DEPTH>=ACT_LATENCY+2, issue_ready_o never deasserts; 1 row/cycle.
//  Latency valid_i -> valid_o: ACT_LATENCY+1 cycles.
// STRUCTURE
//  ita_package: add act_row_t (logic signed [N_PE-1:0][WO-1:0], alias of requant_oup_t) and
//   ACT_LATENCY localparam shared with activation and this block; tile row counter type row_cnt_t.
//  One sub-module: fifo_v3 (common_cells), FALL_THROUGH=0, DEPTH, DATA_WIDTH=N_PE*WO, rst_ni=~rst_i,
//   flush_i=clear_i; overflow detection, valid pipe, credits, row counter local to this module.
// TESTING (N_PE=16, DEPTH=4, ACT_LATENCY=2)
//  1 Streaming: valid_i=1 for 64 cycles, ready_i=1, tile_len_i=64 -> issue_ready_o stays 1, rows out in order
//    starting 3 cycles after first valid_i, last_o only on row 63, count_o <= 1, overflow_o=0.
//  2 Backpressure: ready_i=0, issue only while issue_ready_o=1 -> exactly 4 rows accepted, count_o=4,
//    issue_ready_o=0; release ready_i -> 4 rows drained in order, issue_ready_o returns 1 after first pop.
//  3 Violation: ready_i=0, force valid_i 6 consecutive cycles -> count_o=4, overflow_o=1 sticky, rows 5,6 lost.
//  4 Full + simultaneous push/pop: count=4, ready_i=1 while a push lands -> count stays 4, overflow_o=0.
//  5 Tile wrap: tile_len_i=3, 7 rows -> last_o on rows 2 and 5; tile_len_i=0 -> last_o on every row.
//  6 clear_i with 2 rows queued and 2 in pipe -> next cycle valid_o=0, count_o=0, no late pushes appear;
//    async rst_i pulse mid-stream -> outputs 0 immediately, issue_ready_o=1 after release.

Source files
------------

// File: rtl/ita_activation_out_buffer_pkg.sv
// Shared types and constants for the activation output buffer and its neighbours.
package ita_activation_out_buffer_pkg;

  // Default geometry shared with the activation unit
  localparam int unsigned ITA_N_PE        = 16;
  localparam int unsigned ITA_WO          = 8;
  localparam int unsigned ITA_DEPTH       = 4;
  localparam int unsigned ITA_ACT_LATENCY = 2;
  localparam int unsigned ITA_CNT_W       = 16;

  // One requantised output row: N_PE signed lanes of WO bits
  typedef logic signed [ITA_N_PE-1:0][ITA_WO-1:0] requant_oup_t;
  typedef requant_oup_t act_row_t;

  // Row index inside the current output tile
  typedef logic [ITA_CNT_W-1:0] row_cnt_t;

  // FIFO event in one cycle, encoded as {accepted push, pop}
  typedef enum logic [1:0] {
    EV_IDLE = 2'b00,
    EV_POP  = 2'b01,
    EV_PUSH = 2'b10,
    EV_BOTH = 2'b11
  } fifo_ev_e;

  // Number of set bits in a 32-bit vector (valid-pipe occupancy)
  function automatic logic [5:0] popcount32(input logic [31:0] bits);
    logic [5:0] acc;
    acc = 6'd0;
    for (int i = 0; i < 32; i++) begin
      acc = acc + {5'd0, bits[i]};
    end
    return acc;
  endfunction

endpackage

// File: rtl/ita_activation_out_buffer_fifo.sv
// Show-ahead FIFO (no fall-through). A push into a full FIFO is accepted
// when a pop happens in the same cycle; flush_i beats every other event.
module ita_activation_out_buffer_fifo
  import ita_activation_out_buffer_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned DATA_WIDTH = 128
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          flush_i,
  input  logic                          push_i,
  input  logic [DATA_WIDTH-1:0]         data_i,
  input  logic                          pop_i,
  output logic [DATA_WIDTH-1:0]         data_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [$clog2(DEPTH+1)-1:0]    usage_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]         wr_ptr_r;
  logic [PW-1:0]         rd_ptr_r;
  logic [CW-1:0]         usage_r;
  logic                  do_push_s;
  logic                  do_pop_s;
  fifo_ev_e              ev_s;

  // Circular pointer advance, safe for non-power-of-two depths
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    logic [PW-1:0] n;
    if (p == PW'(DEPTH-1)) begin
      n = {PW{1'b0}};
    end else begin
      n = p + PW'(1);
    end
    return n;
  endfunction

  assign full_o  = (usage_r == CW'(DEPTH));
  assign empty_o = (usage_r == {CW{1'b0}});
  assign usage_o = usage_r;
  assign data_o  = mem_r[rd_ptr_r];

  // Decide which side of the FIFO moves this cycle
  always_comb begin
    do_push_s = push_i & (~full_o | pop_i);
    do_pop_s  = pop_i & ~empty_o;
    ev_s      = fifo_ev_e'({do_push_s, do_pop_s});
  end

  // Pointers and occupancy
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      usage_r  <= {CW{1'b0}};
    end else if (flush_i) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      usage_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (do_pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case (ev_s)
        EV_PUSH: usage_r <= usage_r + CW'(1);
        EV_POP:  usage_r <= usage_r - CW'(1);
        default: usage_r <= usage_r;
      endcase
    end
  end

  // Storage; cleared on reset so the head reads zero out of reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (do_push_s && !flush_i) begin
      mem_r[wr_ptr_r] <= data_i;
    end
  end

endmodule

// File: rtl/ita_activation_out_buffer.sv
// Absorbs the fixed-latency, non-stallable activation output into a
// credit-protected FIFO and presents it downstream with valid/ready.
// Upstream issue is throttled by counting rows still inside the activation
// pipeline; the final row of every tile is tagged with last_o.
module ita_activation_out_buffer
  import ita_activation_out_buffer_pkg::*;
#(
  parameter int unsigned N_PE        = ITA_N_PE,
  parameter int unsigned WO          = ITA_WO,
  parameter int unsigned DEPTH       = ITA_DEPTH,
  parameter int unsigned ACT_LATENCY = ITA_ACT_LATENCY,
  parameter int unsigned CNT_W       = ITA_CNT_W
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          clear_i,
  input  logic                          valid_i,
  output logic                          issue_ready_o,
  input  logic [N_PE*WO-1:0]            act_data_i,
  input  logic [CNT_W-1:0]              tile_len_i,
  output logic [N_PE*WO-1:0]            data_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic                          last_o,
  output logic [$clog2(DEPTH+1)-1:0]    count_o,
  output logic                          overflow_o
);

  localparam int unsigned CW = $clog2(DEPTH+1);

  if (DEPTH < 1) begin : g_bad_depth
    $fatal(1, "ita_activation_out_buffer: DEPTH must be at least 1");
  end
  if ((ACT_LATENCY < 1) || (ACT_LATENCY > 32)) begin : g_bad_latency
    $fatal(1, "ita_activation_out_buffer: ACT_LATENCY must be in 1..32");
  end

  logic [ACT_LATENCY-1:0] valid_pipe_r;
  logic [ACT_LATENCY-1:0] valid_pipe_next_s;
  logic [31:0]            pipe_ext_s;
  logic [5:0]             inflight_next_s;
  logic                   push_s;
  logic                   pop_s;
  logic                   accept_s;
  logic                   full_s;
  logic                   empty_s;
  logic [CW-1:0]          usage_s;
  logic [CW-1:0]          count_next_s;
  logic [15:0]            credit_sum_s;
  logic                   issue_ready_r;
  logic                   issue_ready_next_s;
  logic                   overflow_r;
  logic [CNT_W-1:0]       row_cnt_r;
  logic [CNT_W-1:0]       row_cnt_next_s;
  logic [CNT_W-1:0]       last_idx_s;
  logic                   last_r;
  logic                   last_next_s;
  fifo_ev_e               ev_s;

  // Shift valid_i one step deeper into the pipe model
  if (ACT_LATENCY == 1) begin : g_pipe1
    assign valid_pipe_next_s = valid_i;
  end else begin : g_pipen
    assign valid_pipe_next_s = {valid_pipe_r[ACT_LATENCY-2:0], valid_i};
  end

  // A row leaves the activation unit when its valid reaches the pipe end
  assign push_s   = valid_pipe_r[ACT_LATENCY-1];
  assign pop_s    = valid_o & ready_i;
  assign accept_s = push_s & (~full_s | pop_s);
  assign ev_s     = fifo_ev_e'({accept_s, pop_s});

  ita_activation_out_buffer_fifo #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (N_PE*WO)
  ) i_fifo (
    .clk_i   (clk_i),
    .rst_ni  (~rst_i),
    .flush_i (clear_i),
    .push_i  (push_s),
    .data_i  (act_data_i),
    .pop_i   (pop_s),
    .data_o  (data_o),
    .full_o  (full_s),
    .empty_o (empty_s),
    .usage_o (usage_s)
  );

  assign valid_o       = ~empty_s;
  assign count_o       = usage_s;
  assign issue_ready_o = issue_ready_r;
  assign overflow_o    = overflow_r;
  assign last_o        = last_r;

  // Next occupancy and in-flight rows; the issue credit is computed one
  // cycle ahead so issue_ready_o comes straight from a flop
  always_comb begin
    count_next_s    = usage_s;
    pipe_ext_s      = 32'd0;
    inflight_next_s = 6'd0;
    if (clear_i) begin
      count_next_s = {CW{1'b0}};
    end else begin
      pipe_ext_s[ACT_LATENCY-1:0] = valid_pipe_next_s;
      inflight_next_s             = popcount32(pipe_ext_s);
      case (ev_s)
        EV_PUSH: count_next_s = usage_s + CW'(1);
        EV_POP:  count_next_s = usage_s - CW'(1);
        default: count_next_s = usage_s;
      endcase
    end
    credit_sum_s       = 16'(count_next_s) + 16'(inflight_next_s);
    issue_ready_next_s = (credit_sum_s < 16'(DEPTH));
  end

  // Tile row bookkeeping; a zero tile length behaves as length one
  always_comb begin
    if (tile_len_i == {CNT_W{1'b0}}) begin
      last_idx_s = {CNT_W{1'b0}};
    end else begin
      last_idx_s = tile_len_i - CNT_W'(1);
    end
    row_cnt_next_s = row_cnt_r;
    if (clear_i) begin
      row_cnt_next_s = {CNT_W{1'b0}};
    end else if (pop_s) begin
      if (row_cnt_r == last_idx_s) begin
        row_cnt_next_s = {CNT_W{1'b0}};
      end else begin
        row_cnt_next_s = row_cnt_r + CNT_W'(1);
      end
    end else begin
      row_cnt_next_s = row_cnt_r;
    end
    last_next_s = (count_next_s != {CW{1'b0}}) && (row_cnt_next_s == last_idx_s);
  end

  // Valid pipe, credits, row counter and last flag
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_pipe_r  <= {ACT_LATENCY{1'b0}};
      issue_ready_r <= 1'b0;
      row_cnt_r     <= {CNT_W{1'b0}};
      last_r        <= 1'b0;
    end else if (clear_i) begin
      valid_pipe_r  <= {ACT_LATENCY{1'b0}};
      issue_ready_r <= issue_ready_next_s;
      row_cnt_r     <= {CNT_W{1'b0}};
      last_r        <= 1'b0;
    end else begin
      valid_pipe_r  <= valid_pipe_next_s;
      issue_ready_r <= issue_ready_next_s;
      row_cnt_r     <= row_cnt_next_s;
      last_r        <= last_next_s;
    end
  end

  // Sticky overflow: a row arrived with the FIFO full and nothing leaving
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      overflow_r <= 1'b0;
    end else if (clear_i) begin
      overflow_r <= 1'b0;
    end else if (push_s && full_s && !pop_s) begin
      overflow_r <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ita_activation_out_buffer.sv
// Scoreboard bench for ita_activation_out_buffer (N_PE=16, WO=8, DEPTH=4, ACT_LATENCY=2).
module tb_ita_activation_out_buffer;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          clear_i;
  logic          valid_i;
  logic          issue_ready_o;
  logic [127:0]  act_data_i;
  logic [15:0]   tile_len_i;
  logic [127:0]  data_o;
  logic          valid_o;
  logic          ready_i;
  logic          last_o;
  logic [2:0]    count_o;
  logic          overflow_o;

  typedef struct packed {
    logic [127:0] data;
    logic         last;
  } exp_t;

  exp_t         exp_q[$];
  int           total = 0;
  int           bad   = 0;
  int           exp_idx = 0;
  logic [127:0] dh0, dh1;

  always #5 clk = ~clk;

  ita_activation_out_buffer dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .clear_i       (clear_i),
    .valid_i       (valid_i),
    .issue_ready_o (issue_ready_o),
    .act_data_i    (act_data_i),
    .tile_len_i    (tile_len_i),
    .data_o        (data_o),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .last_o        (last_o),
    .count_o       (count_o),
    .overflow_o    (overflow_o)
  );

  function automatic logic [127:0] mkrow(input int id);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[i*8 +: 8] = 8'(id * 37 + i * 11 + 5);
    return r;
  endfunction

  task automatic chkv(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0b required=%0b", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [127:0] d);
    exp_t e;
    int   tl;
    tl     = (tile_len_i == 16'd0) ? 1 : int'(tile_len_i);
    e.data = d;
    e.last = ((exp_idx % tl) == (tl - 1));
    exp_idx++;
    exp_q.push_back(e);
  endtask

  // Model of the activation unit: data for a row appears two cycles after issue
  task automatic drive(input logic v, input logic [127:0] d, input logic acc);
    act_data_i = dh1;
    dh1        = dh0;
    dh0        = v ? d : 128'd0;
    valid_i    = v;
    clear_i    = 1'b0;
    if (acc) push_exp(d);
  endtask

  task automatic step(input logic v, input logic [127:0] d, input logic acc);
    @(posedge clk);
    #1;
    drive(v, d, acc);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 128'd0, 1'b0);
  endtask

  task automatic do_clear();
    step(1'b0, 128'd0, 1'b0);
    clear_i = 1'b1;
    exp_q.delete();
    exp_idx = 0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || valid_o) && n < 40) begin
      step(1'b0, 128'd0, 1'b0);
      n++;
    end
    chk1(name, (exp_q.size() == 0) && !valid_o, 1'b1);
  endtask

  // Monitor: every accepted output row is checked against the scoreboard head
  always @(negedge clk) begin
    if (!rst_i && !clear_i && valid_o && ready_i) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL mon_unexpected actual=%0h required=none", data_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chkv("mon_data", data_o, e.data);
        chk1("mon_last", last_o, e.last);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_n;
    rst_i = 1'b1; clear_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
    act_data_i = 128'd0; tile_len_i = 16'd64; dh0 = 128'd0; dh1 = 128'd0;

    // Reset state
    #12;
    chk1("rst_issue_ready", issue_ready_o, 1'b0);
    chk1("rst_valid", valid_o, 1'b0);
    chkv("rst_count", 128'(count_o), 128'd0);
    chkv("rst_data", data_o, 128'd0);
    chk1("rst_last", last_o, 1'b0);
    chk1("rst_overflow", overflow_o, 1'b0);
    @(posedge clk); #1; rst_i = 1'b0;
    idle(1);
    chk1("rel_issue_ready", issue_ready_o, 1'b1);

    // 1: streaming 64 rows, one tile
    ready_i = 1'b1;
    for (int k = 0; k < 64; k++) begin
      step(1'b1, mkrow(k), 1'b1);
      chk1("t1_issue_ready", issue_ready_o, 1'b1);
      chk1("t1_valid_latency", valid_o, (k >= 3));
      chk1("t1_count_le1", (count_o <= 3'd1), 1'b1);
    end
    drain("t1_drain");
    chk1("t1_overflow", overflow_o, 1'b0);

    // 2: backpressure, issue only on credit
    ready_i = 1'b0;
    acc_n   = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (issue_ready_o) begin
        drive(1'b1, mkrow(100 + acc_n), 1'b1);
        acc_n++;
      end else begin
        drive(1'b0, 128'd0, 1'b0);
      end
    end
    idle(3);
    chkv("t2_accepted", 128'(acc_n), 128'd4);
    chkv("t2_count", 128'(count_o), 128'd4);
    chk1("t2_issue_ready_low", issue_ready_o, 1'b0);
    idle(1);
    ready_i = 1'b1;
    idle(1);
    chk1("t2_issue_ready_back", issue_ready_o, 1'b1);
    drain("t2_drain");

    // 3: protocol violation, rows 5 and 6 dropped
    ready_i = 1'b0;
    for (int k = 0; k < 6; k++) step(1'b1, mkrow(200 + k), (k < 4));
    idle(3);
    chkv("t3_count", 128'(count_o), 128'd4);
    chk1("t3_overflow", overflow_o, 1'b1);
    ready_i = 1'b1;
    drain("t3_drain");
    chk1("t3_overflow_sticky", overflow_o, 1'b1);
    do_clear();
    idle(1);
    chk1("t3_overflow_cleared", overflow_o, 1'b0);

    // 4: push lands on a full FIFO while a pop happens
    ready_i = 1'b0;
    for (int k = 0; k < 5; k++) step(1'b1, mkrow(300 + k), 1'b1);
    idle(2);
    ready_i = 1'b1;
    idle(1);
    ready_i = 1'b0;
    chkv("t4_count_full", 128'(count_o), 128'd4);
    chk1("t4_no_overflow", overflow_o, 1'b0);
    ready_i = 1'b1;
    drain("t4_drain");

    // 5: tile wrap at 3, then tile length 0
    do_clear();
    tile_len_i = 16'd3;
    for (int k = 0; k < 7; k++) step(1'b1, mkrow(400 + k), 1'b1);
    drain("t5_drain_len3");
    do_clear();
    tile_len_i = 16'd0;
    for (int k = 0; k < 4; k++) step(1'b1, mkrow(450 + k), 1'b1);
    drain("t5_drain_len0");

    // 6: clear with two rows queued and two in the pipe
    do_clear();
    tile_len_i = 16'd64;
    ready_i    = 1'b0;
    for (int k = 0; k < 4; k++) step(1'b1, mkrow(500 + k), 1'b0);
    idle(1);
    chkv("t6_count_before", 128'(count_o), 128'd2);
    clear_i = 1'b1;
    exp_idx = 0;
    idle(1);
    chk1("t6_valid_cleared", valid_o, 1'b0);
    chkv("t6_count_cleared", 128'(count_o), 128'd0);
    for (int k = 0; k < 4; k++) begin
      idle(1);
      chkv("t6_no_late_push", 128'(count_o), 128'd0);
    end

    // 6b: asynchronous reset mid-stream
    ready_i = 1'b1;
    for (int k = 0; k < 6; k++) step(1'b1, mkrow(600 + k), 1'b1);
    #2;
    rst_i   = 1'b1;
    valid_i = 1'b0;
    #1;
    chk1("t6_rst_valid", valid_o, 1'b0);
    chkv("t6_rst_count", 128'(count_o), 128'd0);
    chk1("t6_rst_last", last_o, 1'b0);
    chkv("t6_rst_data", data_o, 128'd0);
    chk1("t6_rst_issue_ready", issue_ready_o, 1'b0);
    exp_q.delete();
    exp_idx = 0;
    dh0 = 128'd0;
    dh1 = 128'd0;
    @(posedge clk); #1; rst_i = 1'b0;
    idle(1);
    chk1("t6_rel_issue_ready", issue_ready_o, 1'b1);
    for (int k = 0; k < 4; k++) begin
      idle(1);
      chk1("t6_rst_no_late_row", valid_o, 1'b0);
    end
    chkv("final_queue_empty", 128'(exp_q.size()), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
